// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared register offsets, window geometry and handshake state type.
// Offsets are byte offsets inside the hub window; the low two address bits are ignored.
// Imported by io_hub and sw_debounce.
package io_hub_pkg;

  localparam int WIN_BYTES = 64;
  localparam int WIN_AW    = $clog2(WIN_BYTES);

  localparam logic [WIN_AW-1:0] OFF_LED   = 6'h00;
  localparam logic [WIN_AW-1:0] OFF_SW    = 6'h04;
  localparam logic [WIN_AW-1:0] OFF_RISE  = 6'h08;
  localparam logic [WIN_AW-1:0] OFF_CYCLE = 6'h0C;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

endpackage

// File: rtl/io_hub_sw_debounce.sv
// sw_debounce: one switch bit -> 2-flop synchroniser, stability counter, stable register.
// Ports: clk, rst (async high), raw_i (asynchronous level), stable_o (debounced level),
//        rise_o (high in the cycle whose closing edge moves stable_o from 0 to 1).
module sw_debounce
  import io_hub_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o
);

  localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  // The synchronised level has disagreed with the stable value long enough.
  assign accept = (sync2_q != stable_q) && (cnt_q == CNT_LAST);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (accept) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = accept && sync2_q;

endmodule

// File: rtl/io_hub.sv
// io_hub: memory-mapped LED / debounced switch / switch-rise / cycle-counter slave.
// Bus: req/we/addr/wdata/be in, registered rdata/ack/err out (ack one cycle after the req edge).
// Pins: switch_in (raw, async) -> per-bit sw_debounce; led_out driven from the LED register.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int          SW_W       = 16,
  parameter int          LED_W      = 16,
  parameter int          DEB_CYCLES = 500000,
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FC00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             we,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       be,
  output logic [31:0]      rdata,
  output logic             ack,
  output logic             err,
  input  logic [SW_W-1:0]  switch_in,
  output logic [LED_W-1:0] led_out
);

  state_t            state_q, state_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [SW_W-1:0]   rise_q, rise_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [SW_W-1:0]   sw_stable, sw_rise;

  logic              acc, in_win, hit_led, hit_sw, hit_rise, hit_cycle, mapped;
  logic [WIN_AW-1:0] off;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^addr[1:0];

  for (genvar g = 0; g < SW_W; g++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (switch_in[g]),
      .stable_o (sw_stable[g]),
      .rise_o   (sw_rise[g])
    );
  end

  // Address decode; the window is naturally aligned so a tag compare suffices.
  assign acc       = (state_q == S_IDLE) && req;
  assign in_win    = (addr[31:WIN_AW] == BASE_ADDR[31:WIN_AW]);
  assign off       = {addr[WIN_AW-1:2], 2'b00};
  assign hit_led   = in_win && (off == OFF_LED);
  assign hit_sw    = in_win && (off == OFF_SW);
  assign hit_rise  = in_win && (off == OFF_RISE);
  assign hit_cycle = in_win && (off == OFF_CYCLE);
  assign mapped    = hit_led || hit_sw || hit_rise || hit_cycle;

  // Handshake FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Handshake FSM: next state. ACK always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake FSM: outputs; everything comes straight from flops.
  always_comb begin
    ack   = (state_q == S_ACK);
    err   = err_q;
    rdata = rdata_q;
  end

  // Register file next-state. Reads sample pre-edge values, so a SW_RISE read
  // never sees a set landing on the same edge.
  always_comb begin
    led_d   = led_q;
    cycle_d = cycle_q + 32'd1;
    rise_d  = rise_q;
    rdata_d = '0;
    err_d   = 1'b0;

    if (acc && we && hit_led) begin
      for (int i = 0; i < LED_W; i++) begin
        if (be[i/8]) led_d[i] = wdata[i];
      end
    end

    if (acc && we && hit_cycle) begin
      for (int k = 0; k < 4; k++) begin
        cycle_d[8*k +: 8] = be[k] ? wdata[8*k +: 8] : cycle_q[8*k +: 8];
      end
    end

    if (acc && we && hit_rise) begin
      for (int i = 0; i < SW_W; i++) begin
        if (be[i/8] && wdata[i]) rise_d[i] = 1'b0;
      end
    end
    // Applied after the clear so a same-edge set wins.
    rise_d = rise_d | sw_rise;

    if (acc) begin
      err_d = !mapped;
      if (!we) begin
        if (hit_led)   rdata_d[LED_W-1:0] = led_q;
        if (hit_sw)    rdata_d[SW_W-1:0]  = sw_stable;
        if (hit_rise)  rdata_d[SW_W-1:0]  = rise_q;
        if (hit_cycle) rdata_d            = cycle_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      cycle_q <= '0;
      rise_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      led_q   <= led_d;
      cycle_q <= cycle_d;
      rise_q  <= rise_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign led_out = led_q;

endmodule

// File: tb/tb_io_hub.sv
module tb_io_hub;

  localparam logic [31:0] BASE = 32'hFFFF_FC00;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack, err;
  logic [15:0] switch_in;
  logic [15:0] led_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] rd;
  logic        e, ak;

  io_hub #(.SW_W(16), .LED_W(16), .DEB_CYCLES(8), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .be        (be),
    .rdata     (rdata),
    .ack       (ack),
    .err       (err),
    .switch_in (switch_in),
    .led_out   (led_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. req is sampled on the next posedge (edge N); ack/err/rdata
  // are captured in cycle N+1; returns at the negedge after N+1 (back in IDLE).
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] r, output logic er,
                     output logic ac);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(posedge clk);
    @(negedge clk);
    ac = ack; r = rdata; er = err;
    req = 1'b0; we = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0; switch_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack",   {31'd0, ack}, 32'd0);
    chk("reset_err",   {31'd0, err}, 32'd0);
    chk("reset_rdata", rdata,        32'd0);
    chk("reset_led",   {16'd0, led_out}, 32'd0);
    rst = 1'b0;

    // First edge after reset release: counter still reads 0 before incrementing.
    bus(1'b0, BASE + 32'h0C, 0, 4'h0, rd, e, ak);
    chk("rst_cycle_ack", {31'd0, ak}, 32'd1);
    chk("rst_cycle", rd, 32'd0);
    bus(1'b0, BASE + 32'h00, 0, 4'h0, rd, e, ak);
    chk("rst_led_rd", rd, 32'd0);
    bus(1'b0, BASE + 32'h04, 0, 4'h0, rd, e, ak);
    chk("rst_sw_rd", rd, 32'd0);
    bus(1'b0, BASE + 32'h08, 0, 4'h0, rd, e, ak);
    chk("rst_rise_rd", rd, 32'd0);
    chk("rst_rise_err", {31'd0, e}, 32'd0);

    // Byte-enabled LED writes.
    bus(1'b1, BASE + 32'h00, 32'hDEAD_BEEF, 4'b0011, rd, e, ak);
    chk("led_w1", {16'd0, led_out}, 32'h0000_BEEF);
    bus(1'b1, BASE + 32'h00, 32'h1234_5678, 4'b0010, rd, e, ak);
    chk("led_w2", {16'd0, led_out}, 32'h0000_56EF);
    bus(1'b0, BASE + 32'h00, 0, 4'h0, rd, e, ak);
    chk("led_rd", rd, 32'h0000_56EF);

    // 5-cycle glitch must be filtered.
    switch_in[3] = 1'b1;
    repeat (5) @(negedge clk);
    switch_in[3] = 1'b0;
    repeat (20) @(negedge clk);
    bus(1'b0, BASE + 32'h04, 0, 4'h0, rd, e, ak);
    chk("sw_glitch", rd, 32'd0);
    bus(1'b0, BASE + 32'h08, 0, 4'h0, rd, e, ak);
    chk("rise_glitch", rd, 32'd0);

    // Long press is accepted and latched in SW_RISE.
    switch_in[3] = 1'b1;
    repeat (20) @(negedge clk);
    bus(1'b0, BASE + 32'h04, 0, 4'h0, rd, e, ak);
    chk("sw_hold", rd, 32'h0000_0008);
    bus(1'b0, BASE + 32'h08, 0, 4'h0, rd, e, ak);
    chk("rise_hold", rd, 32'h0000_0008);
    bus(1'b1, BASE + 32'h08, 32'h0000_0008, 4'b0001, rd, e, ak);
    bus(1'b0, BASE + 32'h08, 0, 4'h0, rd, e, ak);
    chk("rise_w1c", rd, 32'd0);

    // SW writes are ignored without err.
    bus(1'b1, BASE + 32'h04, 32'h0000_0000, 4'hF, rd, e, ak);
    chk("sw_wr_err", {31'd0, e}, 32'd0);
    bus(1'b0, BASE + 32'h04, 0, 4'h0, rd, e, ak);
    chk("sw_wr_ignored", rd, 32'h0000_0008);

    // Release, then re-press so the rise lands on the W1C edge.
    // Raised before edge E0: sync2 high after E0+1, counter 1..7 on E0+2..E0+8,
    // stable and SW_RISE set on E0+9, which is where the clear is sampled.
    switch_in[3] = 1'b0;
    repeat (20) @(negedge clk);
    switch_in[3] = 1'b1;
    repeat (9) @(negedge clk);
    bus(1'b1, BASE + 32'h08, 32'h0000_0008, 4'b0001, rd, e, ak);
    bus(1'b0, BASE + 32'h08, 0, 4'h0, rd, e, ak);
    chk("rise_set_wins", rd, 32'h0000_0008);

    // Load then count: loaded at edge N, read sampled at N+4 sees N+1..N+3 increments.
    bus(1'b1, BASE + 32'h0C, 32'hFFFF_FFFE, 4'hF, rd, e, ak);
    repeat (2) @(negedge clk);
    bus(1'b0, BASE + 32'h0C, 0, 4'h0, rd, e, ak);
    chk("cycle_wrap", rd, 32'h0000_0001);

    // Unmapped accesses.
    bus(1'b0, BASE + 32'h20, 0, 4'h0, rd, e, ak);
    chk("unmap_off_ack",   {31'd0, ak}, 32'd1);
    chk("unmap_off_err",   {31'd0, e},  32'd1);
    chk("unmap_off_rdata", rd,          32'd0);
    bus(1'b0, 32'h0000_1000, 0, 4'h0, rd, e, ak);
    chk("unmap_out_ack",   {31'd0, ak}, 32'd1);
    chk("unmap_out_err",   {31'd0, e},  32'd1);
    chk("unmap_out_rdata", rd,          32'd0);

    // Reset held across a request edge: nothing commits, no ack.
    req = 1'b1; we = 1'b1; addr = BASE; wdata = 32'h0000_1234; be = 4'hF; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_ack", {31'd0, ack}, 32'd0);
    chk("rst_hold_led", {16'd0, led_out}, 32'd0);
    req = 1'b0; we = 1'b0; rst = 1'b0;
    @(negedge clk);

    // Reset right after the request edge aborts the pending ack.
    req = 1'b1; we = 1'b0; addr = BASE + 32'h0C;
    @(posedge clk);
    #1 rst = 1'b1;
    ak = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ak = ak | ack;
      req = 1'b0;
    end
    chk("rst_abort_ack", {31'd0, ak}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
